// File: rtl/ppu_line_doubler.sv
// ppu_line_doubler: double-buffered NES-to-VGA line doubler (256x240 PPU lines -> 512x480 VGA window)
// Ports: Clk/Reset_n (async active-low); pix_en, hc, vc from the VGA timing counter;
// ppu_valid/ppu_pixel write the next line; ppu_line_req asks the PPU for it;
// vga_index/vga_active drive the display; underrun/overrun are sticky error flags.
module ppu_line_doubler (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       pix_en,
  input  logic [9:0] hc,
  input  logic [9:0] vc,
  input  logic       ppu_valid,
  input  logic [5:0] ppu_pixel,
  output logic       ppu_line_req,
  output logic [5:0] vga_index,
  output logic       vga_active,
  output logic       underrun,
  output logic       overrun
);
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
  state_t      state_q;
  logic        bank_q;
  logic [7:0]  wr_ptr_q;
  logic        line_ready_q;
  logic        req_q;
  logic [5:0]  vga_index_q;
  logic        vga_active_q;
  logic        underrun_q;
  logic        overrun_q;
  logic [5:0]  mem_q [0:511];
  logic [9:0]  vc_nxt;
  logic        swap;
  logic        we;
  logic        win;
  logic [7:0]  rd_addr;
  assign vc_nxt  = (vc == 10'd524) ? 10'd0 : vc + 10'd1;
  // Swap at the end of the last VGA line before each even (new NES) line of the picture.
  assign swap    = pix_en && hc == 10'd799 && !vc_nxt[0] && vc_nxt < 10'd480;
  // A swap cycle owns the write side, so a coincident pixel is dropped.
  assign we      = state_q == FILL && ppu_valid && !swap;
  assign win     = hc >= 10'd64 && hc <= 10'd575 && vc < 10'd480;
  assign rd_addr = 8'((hc - 10'd64) >> 1);
  // Bank memory is deliberately left unreset.
  always_ff @(posedge Clk)
    if (we) mem_q[{bank_q, wr_ptr_q}] <= ppu_pixel;
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state_q      <= IDLE;
      bank_q       <= 1'b0;
      wr_ptr_q     <= 8'd0;
      line_ready_q <= 1'b0;
      req_q        <= 1'b0;
      vga_index_q  <= 6'h0F;
      vga_active_q <= 1'b0;
      underrun_q   <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      req_q <= swap;
      if (ppu_valid && (state_q != FILL || swap)) overrun_q <= 1'b1;
      if (swap) begin
        // Without a finished line the bank stays put and the old line is shown again.
        bank_q       <= bank_q ^ line_ready_q;
        underrun_q   <= underrun_q | ~line_ready_q;
        line_ready_q <= 1'b0;
        wr_ptr_q     <= 8'd0;
        state_q      <= FILL;
      end else if (we) begin
        wr_ptr_q <= wr_ptr_q + 8'd1;
        if (wr_ptr_q == 8'd255) begin
          state_q      <= DONE;
          line_ready_q <= 1'b1;
        end
      end
      if (pix_en) begin
        vga_active_q <= win;
        vga_index_q  <= win ? mem_q[{~bank_q, rd_addr}] : 6'h0F;
      end
    end
  assign ppu_line_req = req_q;
  assign vga_index    = vga_index_q;
  assign vga_active   = vga_active_q;
  assign underrun     = underrun_q;
  assign overrun      = overrun_q;
endmodule

// File: tb/tb_ppu_line_doubler.sv
// tb_ppu_line_doubler: directed self-checking bench for ppu_line_doubler
module tb_ppu_line_doubler;
  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       pix_en = 1'b0;
  logic [9:0] hc = 10'd0;
  logic [9:0] vc = 10'd0;
  logic       ppu_valid = 1'b0;
  logic [5:0] ppu_pixel = 6'd0;
  logic       ppu_line_req;
  logic [5:0] vga_index;
  logic       vga_active;
  logic       underrun;
  logic       overrun;
  int         total = 0;
  int         passed = 0;

  ppu_line_doubler dut (
    .Clk(Clk), .Reset_n(Reset_n), .pix_en(pix_en), .hc(hc), .vc(vc),
    .ppu_valid(ppu_valid), .ppu_pixel(ppu_pixel), .ppu_line_req(ppu_line_req),
    .vga_index(vga_index), .vga_active(vga_active), .underrun(underrun), .overrun(overrun)
  );

  always #10 Clk = ~Clk;

  task automatic do_reset();
    @(negedge Clk);
    Reset_n = 1'b0;
    pix_en = 1'b0;
    ppu_valid = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  task automatic pix(input int h, input int v, input bit val);
    @(negedge Clk);
    pix_en = 1'b1;
    hc = 10'(h);
    vc = 10'(v);
    ppu_valid = val;
    ppu_pixel = 6'h15;
    @(negedge Clk);
    pix_en = 1'b0;
    ppu_valid = 1'b0;
  endtask

  task automatic write_px(input int count, input int mul, input int add);
    for (int n = 0; n < count; n++) begin
      @(negedge Clk);
      ppu_valid = 1'b1;
      ppu_pixel = 6'((n * mul + add) % 64);
    end
    @(negedge Clk);
    ppu_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (ppu_line_req !== 1'b0) $display("FAIL rst_req got %b exp 0", ppu_line_req); else passed++;
    total++; if (vga_index !== 6'h0F) $display("FAIL rst_index got %h exp 0f", vga_index); else passed++;
    total++; if (vga_active !== 1'b0) $display("FAIL rst_active got %b exp 0", vga_active); else passed++;
    total++; if (underrun !== 1'b0) $display("FAIL rst_underrun got %b exp 0", underrun); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL rst_overrun got %b exp 0", overrun); else passed++;
  endtask

  task automatic test_first_swap();
    pix(799, 524, 1'b0);
    total++; if (ppu_line_req !== 1'b1) $display("FAIL first_req got %b exp 1", ppu_line_req); else passed++;
    total++; if (underrun !== 1'b1) $display("FAIL first_underrun got %b exp 1", underrun); else passed++;
    @(negedge Clk);
    total++; if (ppu_line_req !== 1'b0) $display("FAIL first_req_pulse got %b exp 0", ppu_line_req); else passed++;
  endtask

  task automatic test_fill_display();
    int th [10] = '{64, 65, 66, 67, 575, 63, 576, 100, 100, 575};
    int tv [10] = '{2, 2, 2, 2, 2, 2, 2, 3, 480, 3};
    logic [5:0] ei [10] = '{6'd0, 6'd0, 6'd1, 6'd1, 6'd63, 6'h0F, 6'h0F, 6'd18, 6'h0F, 6'd63};
    logic ea [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    write_px(256, 1, 0);
    total++; if (overrun !== 1'b0) $display("FAIL fill_overrun got %b exp 0", overrun); else passed++;
    pix(799, 1, 1'b0);
    total++; if (ppu_line_req !== 1'b1) $display("FAIL swap1_req got %b exp 1", ppu_line_req); else passed++;
    for (int i = 0; i < 10; i++) begin
      pix(th[i], tv[i], 1'b0);
      total++; if (vga_index !== ei[i]) $display("FAIL disp_index hc=%0d vc=%0d got %h exp %h", th[i], tv[i], vga_index, ei[i]); else passed++;
      total++; if (vga_active !== ea[i]) $display("FAIL disp_active hc=%0d vc=%0d got %b exp %b", th[i], tv[i], vga_active, ea[i]); else passed++;
    end
    @(negedge Clk);
    hc = 10'd66;
    vc = 10'd2;
    @(negedge Clk);
    total++; if (vga_index !== 6'd63) $display("FAIL hold_index got %h exp 3f", vga_index); else passed++;
  endtask

  task automatic test_overrun_257();
    write_px(256, 5, 7);
    total++; if (overrun !== 1'b0) $display("FAIL ovr256 got %b exp 0", overrun); else passed++;
    write_px(1, 0, 42);
    total++; if (overrun !== 1'b1) $display("FAIL ovr257 got %b exp 1", overrun); else passed++;
    pix(799, 3, 1'b0);
    pix(64, 4, 1'b0);
    total++; if (vga_index !== 6'd7) $display("FAIL ovr_entry0 got %h exp 07", vga_index); else passed++;
    pix(70, 4, 1'b0);
    total++; if (vga_index !== 6'd22) $display("FAIL ovr_entry3 got %h exp 16", vga_index); else passed++;
    pix(575, 5, 1'b0);
    total++; if (vga_index !== 6'd2) $display("FAIL ovr_entry255 got %h exp 02", vga_index); else passed++;
  endtask

  task automatic test_underrun_repeat();
    pix(799, 5, 1'b0);
    total++; if (ppu_line_req !== 1'b1) $display("FAIL rep_req got %b exp 1", ppu_line_req); else passed++;
    total++; if (underrun !== 1'b1) $display("FAIL rep_underrun got %b exp 1", underrun); else passed++;
    pix(64, 6, 1'b0);
    total++; if (vga_index !== 6'd7) $display("FAIL rep_line6 got %h exp 07", vga_index); else passed++;
    pix(575, 7, 1'b0);
    total++; if (vga_index !== 6'd2) $display("FAIL rep_line7 got %h exp 02", vga_index); else passed++;
  endtask

  task automatic test_swap_valid();
    do_reset();
    pix(799, 524, 1'b0);
    total++; if (overrun !== 1'b0) $display("FAIL sv_pre_overrun got %b exp 0", overrun); else passed++;
    write_px(10, 1, 30);
    pix(799, 1, 1'b1);
    total++; if (ppu_line_req !== 1'b1) $display("FAIL sv_req got %b exp 1", ppu_line_req); else passed++;
    total++; if (overrun !== 1'b1) $display("FAIL sv_overrun got %b exp 1", overrun); else passed++;
    write_px(256, 3, 1);
    pix(799, 3, 1'b0);
    pix(64, 4, 1'b0);
    total++; if (vga_index !== 6'd1) $display("FAIL sv_entry0 got %h exp 01", vga_index); else passed++;
    pix(575, 4, 1'b0);
    total++; if (vga_index !== 6'd62) $display("FAIL sv_entry255 got %h exp 3e", vga_index); else passed++;
  endtask

  task automatic test_mid_fill_reset();
    do_reset();
    write_px(1, 0, 9);
    total++; if (overrun !== 1'b1) $display("FAIL idle_overrun got %b exp 1", overrun); else passed++;
    pix(799, 524, 1'b0);
    pix(64, 0, 1'b0);
    total++; if (vga_active !== 1'b1) $display("FAIL mr_active_pre got %b exp 1", vga_active); else passed++;
    write_px(100, 1, 0);
    @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    total++; if (vga_active !== 1'b0) $display("FAIL mr_active got %b exp 0", vga_active); else passed++;
    total++; if (vga_index !== 6'h0F) $display("FAIL mr_index got %h exp 0f", vga_index); else passed++;
    total++; if (underrun !== 1'b0) $display("FAIL mr_underrun got %b exp 0", underrun); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL mr_overrun got %b exp 0", overrun); else passed++;
    total++; if (ppu_line_req !== 1'b0) $display("FAIL mr_req got %b exp 0", ppu_line_req); else passed++;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    pix(799, 0, 1'b0);
    total++; if (ppu_line_req !== 1'b0) $display("FAIL mr_noswap_vc0 got %b exp 0", ppu_line_req); else passed++;
    pix(799, 2, 1'b0);
    total++; if (ppu_line_req !== 1'b0) $display("FAIL mr_noswap_vc2 got %b exp 0", ppu_line_req); else passed++;
    pix(799, 479, 1'b0);
    total++; if (ppu_line_req !== 1'b0) $display("FAIL mr_noswap_vc479 got %b exp 0", ppu_line_req); else passed++;
    pix(798, 1, 1'b0);
    total++; if (ppu_line_req !== 1'b0) $display("FAIL mr_noswap_hc798 got %b exp 0", ppu_line_req); else passed++;
    pix(799, 1, 1'b0);
    total++; if (ppu_line_req !== 1'b1) $display("FAIL mr_swap_req got %b exp 1", ppu_line_req); else passed++;
    total++; if (underrun !== 1'b1) $display("FAIL mr_swap_underrun got %b exp 1", underrun); else passed++;
  endtask

  initial begin
    test_reset();
    test_first_swap();
    test_fill_display();
    test_overrun_257();
    test_underrun_repeat();
    test_swap_valid();
    test_mid_fill_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
